// File: rtl/r2l_exp.sv
// Right-to-left binary exponentiation C = A^B mod 2^k with overflow flag; one exponent bit per cycle.
// Latency: bit_length(B) RUN cycles then a one-cycle done pulse; start is ignored unless IDLE.
module r2l_exp #(
   parameter int k = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [k-1:0] A,
   input  logic [k-1:0] B,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic [k-1:0] C,
   output logic         ovf
);

   localparam int CW = $clog2(k) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          state_q;
   logic [k-1:0]    rega_q;
   logic [k-1:0]    regb_q;
   logic [k-1:0]    c_q;
   logic [CW-1:0]   cnt_q;
   logic            aovf_q;
   logic            ovf_q;
   logic            busy_q;
   logic            done_q;

   logic [2*k-1:0]  prod_ca;
   logic [2*k-1:0]  prod_aa;
   logic            last_bit;

   assign prod_ca  = {{k{1'b0}}, c_q}    * {{k{1'b0}}, rega_q};
   assign prod_aa  = {{k{1'b0}}, rega_q} * {{k{1'b0}}, rega_q};
   // The counter bound is a safety net; the shifted exponent normally ends the run first.
   assign last_bit = ((regb_q >> 1) == '0) || (cnt_q == CW'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         rega_q  <= '0;
         regb_q  <= '0;
         c_q     <= k'(1);
         cnt_q   <= CW'(k);
         aovf_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  c_q   <= k'(1);
                  ovf_q <= 1'b0;
                  if (B != '0) begin
                     rega_q  <= A;
                     regb_q  <= B;
                     aovf_q  <= 1'b0;
                     cnt_q   <= CW'(k);
                     busy_q  <= 1'b1;
                     state_q <= S_RUN;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
            S_RUN: begin
               if (regb_q[0]) begin
                  c_q <= prod_ca[k-1:0];
                  if ((prod_ca[2*k-1:k] != '0) || aovf_q) ovf_q <= 1'b1;
               end
               rega_q <= prod_aa[k-1:0];
               regb_q <= regb_q >> 1;
               cnt_q  <= cnt_q - CW'(1);
               // A squaring overflow in the last cycle can never reach C, so it is not recorded.
               if (!last_bit && (prod_aa[2*k-1:k] != '0)) aovf_q <= 1'b1;
               if (last_bit) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign C    = c_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_r2l_exp.sv
// Directed-vector bench for r2l_exp with hand-computed results.
module tb_r2l_exp;

   logic        clk;
   logic        rst_n;
   logic [15:0] a;
   logic [15:0] b;
   logic        start;
   logic        busy;
   logic        done;
   logic [15:0] c;
   logic        ovf;

   int n_checks = 0;
   int n_errors = 0;

   r2l_exp #(.k(16)) dut (
      .clk   (clk),
      .rst   (rst_n),
      .A     (a),
      .B     (b),
      .start (start),
      .busy  (busy),
      .done  (done),
      .C     (c),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Issue one operation and follow it to done; optionally pulse a competing start mid-run.
   task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input int nrun, input logic [15:0] expc, input logic expo, input bit inj);
      int busy_cnt;
      int done_at;
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      busy_cnt = 0;
      done_at  = 0;
      for (int i = 1; i <= 40 && done_at == 0; i++) begin
         @(negedge clk);
         if (inj && i == 1) begin
            a = 16'd2; b = 16'd16; start = 1'b1;
         end
         if (inj && i == 2) start = 1'b0;
         check({tag, "_busy_done_excl"}, {31'd0, busy & done}, 32'd0);
         if (busy) busy_cnt++;
         if (done) begin
            done_at = i;
            check({tag, "_C"}, {16'd0, c}, {16'd0, expc});
            check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, expo});
         end
      end
      check({tag, "_busy_cycles"}, busy_cnt, nrun);
      check({tag, "_done_cycle"}, done_at, nrun + 1);
   endtask

   initial begin
      rst_n = 1'b0; a = '0; b = '0; start = 1'b0;
      #12;
      check("rst_C", {16'd0, c}, 32'd1);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op("3p5",      16'd3,   16'd5,      3,  16'd243,   1'b0, 1'b0);
      do_op("7p0",      16'd7,   16'd0,      0,  16'd1,     1'b0, 1'b0);
      do_op("0p0",      16'd0,   16'd0,      0,  16'd1,     1'b0, 1'b0);
      do_op("2p16",     16'd2,   16'd16,     5,  16'd0,     1'b1, 1'b0);
      do_op("2p15",     16'd2,   16'd15,     4,  16'd32768, 1'b0, 1'b0);
      do_op("255p2",    16'd255, 16'd2,      2,  16'd65025, 1'b0, 1'b0);
      do_op("0p7",      16'd0,   16'd7,      3,  16'd0,     1'b0, 1'b0);
      do_op("1pFFFF",   16'd1,   16'hFFFF,   16, 16'd1,     1'b0, 1'b0);
      do_op("3p5_inj",  16'd3,   16'd5,      3,  16'd243,   1'b0, 1'b1);
      // Back-to-back: this start lands in the cycle right after the previous done.
      do_op("3p3_b2b",  16'd3,   16'd3,      2,  16'd27,    1'b0, 1'b0);

      // Result must be held while idle.
      repeat (3) @(negedge clk);
      check("hold_C", {16'd0, c}, 32'd27);
      check("hold_done", {31'd0, done}, 32'd0);

      // Abort mid-run with asynchronous reset.
      @(negedge clk);
      a = 16'd3; b = 16'h00FF; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_busy_before", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_C", {16'd0, c}, 32'd1);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      repeat (2) @(negedge clk);
      check("abort_done_held", {31'd0, done}, 32'd0);
      rst_n = 1'b1;

      do_op("post_rst", 16'd3,   16'd5,      3,  16'd243,   1'b0, 1'b0);
      do_op("5p4",      16'd5,   16'd4,      3,  16'd625,   1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/r2l_exp.md
Name: r2l_exp

Overview:
- Right-to-left binary exponentiation engine; computes C = A^B, scanning exponent B from LSB to MSB. It is the opposite scan direction of the team's left-to-right square-and-multiply unit.
- Self-contained: controller FSM and datapath in one block.
- Per iteration: conditional multiply C <= C*A when the current bit is 1, and unconditional square A <= A*A, both in the same cycle.
- Sits beside the L2R unit so the two can be cross-checked. Same start/done handshake style.

Parameters:
- k, 16, operand width of A, B and the result C. All arithmetic is modulo 2^k.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- A  input  k  base; sampled only when start is accepted
- B  input  k  exponent; sampled only when start is accepted
- start  input  1  request; accepted only in IDLE
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; C is valid in the same cycle
- C  output  k  result, A^B mod 2^k; held until the next accepted start
- ovf  output  1  true result >= 2^k; valid with done and held like C

Behaviour:
- Reset (asynchronous, rst=0):
  - state=IDLE; C=1; ovf=0; busy=0; done=0.
  - Internal RegA=0, RegB=0, counter=k, a_ovf=0.
  - Reset asserted mid-RUN aborts the operation immediately, with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and B!=0 → load RegA=A, RegB=B, C=1, ovf=0, a_ovf=0, counter=k; next state RUN.
  - start=1 and B==0 → C=1, ovf=0; next state DONE (covers 0^0 = 1).
  - start=0 → remain in IDLE.
- RUN, one exponent bit per cycle:
  - If RegB[0]=1: C <= low k bits of C*RegA.
  - In every RUN cycle: RegA <= low k bits of RegA*RegA; RegB <= RegB>>1; counter <= counter-1.
  - Exit to DONE when (RegB>>1)==0 or counter==1. Otherwise stay in RUN.
  - Number of RUN cycles = bit length of B (1..k).
- DONE: done=1 for exactly one cycle; next state IDLE.
- busy=1 exactly while state==RUN. busy and done are never high together.
- start asserted in RUN or DONE is ignored; no queuing.
- Latency: start sampled at edge E0. RUN occupies the n cycles after E0, where n = bit length of B. done is high in cycle n+1 after E0. For B==0, done is high in the cycle right after E0.
- Multipliers: two combinational k×k→2k multipliers, one for C*RegA and one for RegA*RegA. Only the low k bits are stored.
- Overflow tracking:
  - a_ovf (sticky): set when the upper k bits of RegA*RegA are nonzero. It is not updated in the final RUN cycle.
  - ovf (sticky): set on a multiply cycle (RegB[0]=1) when the upper k bits of C*RegA are nonzero, or when a_ovf=1.
  - A=0 or A=1 never sets ovf.
- Counter width: $clog2(k)+1 bits. No wrap is reachable, because RUN exits by counter==1 at the latest.
- C and ovf change only on an accepted start or in RUN. Otherwise they hold the last result.

Test Plan:
- k=16, A=3, B=5 → busy for 3 cycles; done in the 4th cycle after start; C=243, ovf=0.
- A=7, B=0 → no busy; done the cycle after start; C=1, ovf=0. Repeat with A=0 → C=1.
- A=2, B=16 → 5 RUN cycles; C=0, ovf=1. A=2, B=15 → C=32768, ovf=0. A=255, B=2 → C=65025, ovf=0.
- A=0, B=7 → C=0, ovf=0. A=1, B=16'hFFFF → 16 RUN cycles, C=1, ovf=0.
- Pulse start again during RUN with different A/B → ignored; the original result completes. A start in the cycle after done is accepted.
- Drop rst low mid-RUN (A=3, B=16'h00FF) → C=1, busy=0, done stays 0 immediately. A new run after release gives correct C.
